// File: rtl/mem_fill_arbiter.sv
// Purpose : shares one pipelined main memory between I-cache fills, D-cache fills and D-cache stores.
// Latency : store = ack in IDLE, write next cycle; fill = 8 back-to-back reads, done one cycle after the 8th return.
// Backpres: requesters hold their request until ack/done; nothing is accepted outside IDLE.
// Ports   : i_miss/d_miss (+addr) fill requests, d_wr_* store request, *_fill_we/fill_word/fill_data
//           steer returned words, *_fill_done completion pulses, mem_* memory port, busy = not IDLE.
module mem_fill_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        d_wr_ack,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        busy
);
    localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W  = $clog2(WORDS_PER_BLOCK + 1);
    localparam logic [CNT_W-1:0]  ISSUE_END = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_DONE} state_t;

    // Owner / last_grant encoding: 0 = I-cache, 1 = D-cache.
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [WORD_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [15:0]        base_q, base_d;
    logic [15:0]        wr_addr_q, wr_addr_d;
    logic [15:0]        wr_data_q, wr_data_d;

    logic               grant;
    logic               last_recv;

    // Round-robin only matters when both misses compete; a lone miss is
    // granted without disturbing the fairness history.
    always_comb begin
        grant = d_miss;
        if (i_miss && d_miss) begin
            grant = ~last_grant_q;
        end
    end

    assign last_recv = mem_rvalid && (recv_cnt_q == LAST_WORD);

    // State register plus datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            base_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (d_wr_req) begin
                    state_d = S_WRITE;
                end else if (i_miss || d_miss) begin
                    state_d = S_FILL;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_FILL:  if (last_recv) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (d_wr_req) begin
                    wr_addr_d = d_wr_addr;
                    wr_data_d = d_wr_data;
                end else if (i_miss || d_miss) begin
                    owner_d     = grant;
                    base_d      = (grant ? d_miss_addr : i_miss_addr) & 16'hFFF0;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    if (i_miss && d_miss) begin
                        last_grant_d = grant;
                    end
                end
            end
            S_FILL: begin
                if (issue_cnt_q < ISSUE_END) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                // Wraps back to 0 on the last word, ready for the next fill.
                if (mem_rvalid) begin
                    recv_cnt_d = recv_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output logic.
    always_comb begin
        d_wr_ack    = 1'b0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = mem_rdata;
        fill_word   = recv_cnt_q;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: d_wr_ack = d_wr_req && !rst;
            S_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = wr_data_q;
            end
            S_FILL: begin
                if (issue_cnt_q < ISSUE_END) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + 16'({issue_cnt_q[WORD_W-1:0], 1'b0});
                end
                i_fill_we = mem_rvalid && !owner_q;
                d_fill_we = mem_rvalid &&  owner_q;
            end
            S_DONE: begin
                i_fill_done = !owner_q;
                d_fill_done =  owner_q;
            end
            default: ;
        endcase
    end

    // A memory at least MEM_LAT deep can never return word n before word
    // n+MEM_LAT (or the whole burst) has been issued.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_FILL && mem_rvalid) begin
            assert (int'(issue_cnt_q) >=
                    ((int'(recv_cnt_q) + MEM_LAT > WORDS_PER_BLOCK) ?
                     WORDS_PER_BLOCK : int'(recv_cnt_q) + MEM_LAT));
        end
    end

endmodule
